// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared board constants, colour type and line-clear state encoding
// Purpose: board geometry defaults, colour width, empty-cell colour and the
//          line-clear FSM state enum shared by the RTL and the bench.
// Ports:   none (package).
package tetris_pkg;

  localparam int BOARD_COLS = 10;   // board width in cells
  localparam int BOARD_ROWS = 24;   // board height in cells, row 0 = top
  localparam int COLOR_W    = 6;

  localparam logic [COLOR_W-1:0] EMPTY = '0;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    COPY_RD,
    COPY_WR,
    CLEAR,
    DONE
  } state_t;

endpackage

// File: rtl/line_clear_if.sv
// rtl/line_clear_if.sv - single-port board RAM bus
// Purpose: groups the shared-address board RAM signals.
// Ports:   none; modport master = line-clear controller, slave = board RAM.
//          ram_Q    : read data, valid one cycle after ram_addr
//          ram_addr : cell address row*COLS+col
//          ram_data : write data
//          ram_wren : write enable
interface line_clear_if;
  import tetris_pkg::*;

  logic [COLOR_W-1:0] ram_Q;
  logic [7:0]         ram_addr;
  logic [COLOR_W-1:0] ram_data;
  logic               ram_wren;

  modport master (
    input  ram_Q,
    output ram_addr,
    output ram_data,
    output ram_wren
  );

  modport slave (
    output ram_Q,
    input  ram_addr,
    input  ram_data,
    input  ram_wren
  );

endinterface

// File: rtl/cell_addr.sv
// rtl/cell_addr.sv - combinational board cell address generator
// Purpose: addr_o = row_i*COLS + col_i, evaluated at 8 bits.
// Ports:   row_i  : row index (RW bits)
//          col_i  : column index (CW bits)
//          addr_o : 8-bit RAM address
module cell_addr #(
  parameter int COLS = 10,
  parameter int RW   = 5,
  parameter int CW   = 4
) (
  input  logic [RW-1:0] row_i,
  input  logic [CW-1:0] col_i,
  output logic [7:0]    addr_o
);

  // Operands widened to 8 bits before the multiply so no partial product
  // is truncated for boards up to 256 cells.
  always_comb begin
    addr_o = 8'(row_i) * 8'(COLS) + 8'(col_i);
  end

endmodule

// File: rtl/line_clear.sv
// rtl/line_clear.sv - scans the board bottom-up, removes full rows and compacts the rest
// Purpose: after a piece locks, walks rows from the bottom with a source and a
//          destination row pointer; full rows are skipped, surviving rows are
//          copied down, and the vacated top rows are cleared to EMPTY.
// Ports:   clk, reset     : clock, synchronous active-high reset
//          start          : single-cycle scan request (ignored while busy)
//          ram            : board RAM bus (line_clear_if.master)
//          busy           : pass in progress
//          done           : one-cycle end-of-pass pulse
//          lines_cleared  : full rows removed by the last pass
module line_clear
  import tetris_pkg::*;
#(
  parameter int COLS = BOARD_COLS,
  parameter int ROWS = BOARD_ROWS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  line_clear_if.master ram,
  output logic         busy,
  output logic         done,
  output logic [4:0]   lines_cleared
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = $clog2(COLS + 1);   // column counter also holds the capture slot COLS

  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [CW-1:0] CAP_COL  = CW'(COLS);

  state_t        state_q, state_d;
  logic [RW-1:0] src_q, src_d;
  logic [RW-1:0] dst_q, dst_d;
  logic [CW-1:0] col_q, col_d;
  logic [4:0]    lines_q, lines_d;
  logic          full_q, full_d;

  logic [RW-1:0] a_row;
  logic [CW-1:0] a_col;
  logic          cell_set;
  logic          row_full;

  assign cell_set = (ram.ram_Q != EMPTY);
  // Only meaningful in the capture slot, where ram_Q holds the last column.
  assign row_full = full_q & cell_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      col_q   <= '0;
      lines_q <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      col_q   <= col_d;
      lines_q <= lines_d;
      full_q  <= full_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    col_d   = col_q;
    lines_d = lines_q;
    full_d  = full_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CHECK;
          src_d   = LAST_ROW;
          dst_d   = LAST_ROW;
          col_d   = '0;
          lines_d = '0;
          full_d  = 1'b1;
        end
      end
      CHECK: begin
        if (col_q != CAP_COL) begin
          // ram_Q lags the address by one cycle, so slot c sees column c-1.
          if (col_q != '0) full_d = full_q & cell_set;
          col_d = col_q + 1'b1;
        end else begin
          col_d  = '0;
          full_d = 1'b1;
          if (row_full) begin
            lines_d = lines_q + 1'b1;
            if (src_q == '0) state_d = CLEAR;   // dst still points at the lowest vacated row
            else             src_d   = src_q - 1'b1;
          end else if (src_q == dst_q) begin
            // src==dst means nothing removed so far; row 0 ends the pass directly.
            if (src_q == '0) begin
              state_d = DONE;
            end else begin
              src_d = src_q - 1'b1;
              dst_d = dst_q - 1'b1;
            end
          end else begin
            state_d = COPY_RD;
          end
        end
      end
      COPY_RD: begin
        state_d = COPY_WR;
      end
      COPY_WR: begin
        if (col_q != LAST_COL) begin
          col_d   = col_q + 1'b1;
          state_d = COPY_RD;
        end else begin
          col_d = '0;
          dst_d = dst_q - 1'b1;
          if (src_q == '0) begin
            state_d = CLEAR;
          end else begin
            src_d   = src_q - 1'b1;
            state_d = CHECK;
          end
        end
      end
      CLEAR: begin
        if (col_q != LAST_COL) begin
          col_d = col_q + 1'b1;
        end else begin
          col_d = '0;
          if (dst_q == '0) state_d = DONE;
          else             dst_d   = dst_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy         = (state_q != IDLE);
    done         = (state_q == DONE);
    ram.ram_wren = 1'b0;
    ram.ram_data = EMPTY;
    a_row        = '0;
    a_col        = '0;
    unique case (state_q)
      CHECK: begin
        a_row = src_q;
        // Capture slot re-presents the last column to stay inside the row.
        a_col = (col_q == CAP_COL) ? LAST_COL : col_q;
      end
      COPY_RD: begin
        a_row = src_q;
        a_col = col_q;
      end
      COPY_WR: begin
        a_row        = dst_q;
        a_col        = col_q;
        ram.ram_wren = 1'b1;
        ram.ram_data = ram.ram_Q;
      end
      CLEAR: begin
        a_row        = dst_q;
        a_col        = col_q;
        ram.ram_wren = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign lines_cleared = lines_q;

  cell_addr #(
    .COLS (COLS),
    .RW   (RW),
    .CW   (CW)
  ) u_cell_addr (
    .row_i  (a_row),
    .col_i  (a_col),
    .addr_o (ram.ram_addr)
  );

endmodule

// File: tb/tb_line_clear.sv
// tb/tb_line_clear.sv - directed self-checking bench for line_clear
module tb_line_clear;
  import tetris_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy;
  logic       done;
  logic [4:0] lines_cleared;

  line_clear_if bus();

  line_clear #(
    .COLS (BOARD_COLS),
    .ROWS (BOARD_ROWS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .ram           (bus),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared)
  );

  always #5 clk = ~clk;

  logic [COLOR_W-1:0] mem     [0:255];
  logic [COLOR_W-1:0] exp_mem [0:255];
  logic               ld_clr;
  logic               ld_en;
  logic [7:0]         ld_addr;
  logic [COLOR_W-1:0] ld_data;
  logic               cnt_clr;
  int                 wr_count;
  int                 done_count;

  always @(posedge clk) begin
    if (ld_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (bus.ram_wren) begin
      mem[bus.ram_addr] <= bus.ram_data;
    end
    bus.ram_Q <= mem[bus.ram_addr];
    if (cnt_clr) begin
      wr_count   <= 0;
      done_count <= 0;
    end else begin
      if (bus.ram_wren) wr_count <= wr_count + 1;
      if (done)         done_count <= done_count + 1;
    end
  end

  int n_checks = 0;
  int n_err    = 0;
  int cyc, busy1, lines1, busy_post, done_post, first_done, found;

  task automatic check(input string tag, input int obs, input int expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int board_diffs();
    int n = 0;
    for (int i = 0; i < BOARD_ROWS * BOARD_COLS; i++)
      if (mem[i] !== exp_mem[i]) n++;
    return n;
  endfunction

  task automatic wipe();
    ld_clr = 1'b1;
    for (int i = 0; i < 256; i++) exp_mem[i] = '0;
    @(negedge clk);
    ld_clr = 1'b0;
  endtask

  task automatic poke(input int r, input int c, input int v);
    ld_en   = 1'b1;
    ld_addr = 8'(r * BOARD_COLS + c);
    ld_data = COLOR_W'(v);
    exp_mem[r * BOARD_COLS + c] = COLOR_W'(v);
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic fill_row(input int r, input int v);
    for (int c = 0; c < BOARD_COLS; c++) poke(r, c, v);
  endtask

  task automatic load_two_row_board();
    wipe();
    fill_row(23, 3);
    for (int c = 0; c < 5; c++) poke(22, c, 5);
    for (int c = 0; c < BOARD_COLS; c++) begin
      exp_mem[23 * BOARD_COLS + c] = (c < 5) ? 6'd5 : 6'd0;
      exp_mem[22 * BOARD_COLS + c] = 6'd0;
    end
  endtask

  // Cycle 1 is the cycle right after the start edge.
  task automatic run_pass();
    cnt_clr = 1'b1;
    start   = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    start   = 1'b0;
    cyc     = 1;
    busy1   = int'(busy);
    lines1  = int'(lines_cleared);
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    busy_post = int'(busy);
    done_post = int'(done);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    ld_clr  = 1'b0;
    ld_en   = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    cnt_clr = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy",  int'(busy), 0);
    check("rst_done",  int'(done), 0);
    check("rst_wren",  int'(bus.ram_wren), 0);
    check("rst_addr",  int'(bus.ram_addr), 0);
    check("rst_data",  int'(bus.ram_data), 0);
    check("rst_lines", int'(lines_cleared), 0);
    reset   = 1'b0;
    cnt_clr = 1'b0;
    @(negedge clk);

    // Empty board
    wipe();
    run_pass();
    check("empty_cycles",    cyc, 265);
    check("empty_busy1",     busy1, 1);
    check("empty_writes",    wr_count, 0);
    check("empty_lines",     int'(lines_cleared), 0);
    check("empty_dones",     done_count, 1);
    check("empty_busy_post", busy_post, 0);
    check("empty_done_post", done_post, 0);

    // Bottom row full, partial row above drops into it
    load_two_row_board();
    run_pass();
    check("one_cycles", cyc, 735);
    check("one_lines",  int'(lines_cleared), 1);
    check("one_writes", wr_count, 240);
    check("one_board",  board_diffs(), 0);
    repeat (5) @(negedge clk);
    check("one_lines_held", int'(lines_cleared), 1);

    // Four full rows, single cell above lands on the bottom row
    wipe();
    for (int r = 20; r < 24; r++) fill_row(r, 7);
    poke(19, 6, 9);
    for (int i = 0; i < 256; i++) exp_mem[i] = '0;
    exp_mem[23 * BOARD_COLS + 6] = 6'd9;
    run_pass();
    check("four_lines_at_start", lines1, 0);
    check("four_cycles", cyc, 705);
    check("four_lines",  int'(lines_cleared), 4);
    check("four_writes", wr_count, 240);
    check("four_board",  board_diffs(), 0);

    // Only the top row full: cleared in place, nothing copied
    wipe();
    fill_row(0, 2);
    poke(10, 3, 4);
    exp_mem[0 * BOARD_COLS + 0] = '0;
    for (int c = 0; c < BOARD_COLS; c++) exp_mem[c] = '0;
    run_pass();
    check("top_cycles", cyc, 275);
    check("top_lines",  int'(lines_cleared), 1);
    check("top_writes", wr_count, 10);
    check("top_board",  board_diffs(), 0);

    // Reset in the middle of a copy
    load_two_row_board();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 2000; i++) begin
      if (bus.ram_wren) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("midrst_found_write", found, 1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_wren",  int'(bus.ram_wren), 0);
    check("midrst_busy",  int'(busy), 0);
    check("midrst_done",  int'(done), 0);
    check("midrst_addr",  int'(bus.ram_addr), 0);
    check("midrst_data",  int'(bus.ram_data), 0);
    check("midrst_lines", int'(lines_cleared), 0);
    // Reset wins over a simultaneous start
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("rst_over_start_busy", int'(busy), 0);
    @(negedge clk);
    check("rst_over_start_idle", int'(busy), 0);
    load_two_row_board();
    run_pass();
    check("rerun_cycles", cyc, 735);
    check("rerun_lines",  int'(lines_cleared), 1);
    check("rerun_board",  board_diffs(), 0);

    // start pulsed again while busy
    wipe();
    cnt_clr = 1'b1;
    start   = 1'b1;
    @(negedge clk);
    cnt_clr    = 1'b0;
    start      = 1'b0;
    cyc        = 1;
    first_done = 0;
    while (cyc < 600) begin
      @(negedge clk);
      cyc++;
      start = (cyc == 100);
      if (done && first_done == 0) first_done = cyc;
    end
    start = 1'b0;
    check("rebusy_first_done", first_done, 265);
    check("rebusy_dones",      done_count, 1);
    check("rebusy_idle",       int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
